// File: rtl/keypad_pkg.sv
// Shared sizes, state/result encodings and the row-priority helper for the keypad scanner.
package keypad_pkg;

  localparam int NCOL = 5;
  localparam int NROW = 4;
  localparam int CW   = 3;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } deb_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_res_e;

  // 1-based index of the lowest-numbered asserted row, 0 when none is asserted.
  function automatic coord_t lowest_row(input logic [NROW-1:0] low);
    coord_t r;
    r = '0;
    for (int j = NROW - 1; j >= 0; j--) begin
      if (low[j]) r = coord_t'(j + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous row sense lines; idles high like the pulled-up rows.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// Column-walking 5x4 keypad scanner with whole-frame debounce and a one-cycle new-press strobe.
//   state        | meaning
//   RELEASED     | no key held, waiting for a single-key frame
//   PRESS_PEND   | candidate key seen in cnt consecutive frames
//   PRESSED      | key accepted and presented on col/row
//   RELEASE_PEND | held key missing for cnt consecutive frames
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [NCOL-1:0] col_n,
  input  logic [NROW-1:0] row_n,
  output logic [CW-1:0]   col,
  output logic [CW-1:0]   row,
  output logic            key_valid,
  output logic            key_pulse
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEB_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_SCANS);
  localparam logic [CW-1:0] COL_LAST  = CW'(NCOL - 1);

  logic [NROW-1:0] row_s;
  logic [NROW-1:0] row_low;
  logic [SW-1:0]   slot_q;
  logic [CW-1:0]   colidx_q;
  coord_t          samp_col;
  logic            sample;
  logic            frame_end;

  logic            acc_hit_q, acc_multi_q;
  coord_t          acc_col_q, acc_row_q;
  logic            mrg_hit, mrg_multi;
  coord_t          mrg_col, mrg_row;
  frame_res_e      res_kind;

  deb_state_e      state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d, cnt_inc;
  coord_t          cand_col_q, cand_col_d, cand_row_q, cand_row_d;
  coord_t          col_q, col_d, row_q, row_d;
  logic            valid_q, valid_d, pulse_q, pulse_d;
  logic            res_key, same_cand, same_held;

  sync2 #(.WIDTH(NROW)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (row_n),
    .q_o   (row_s)
  );

  assign row_low   = ~row_s;
  assign samp_col  = colidx_q + CW'(1);
  assign sample    = (slot_q == SLOT_LAST);
  assign frame_end = sample && (colidx_q == COL_LAST);
  assign col_n     = ~(NCOL'(1) << colidx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      colidx_q <= '0;
    end else if (sample) begin
      slot_q   <= '0;
      colidx_q <= (colidx_q == COL_LAST) ? '0 : colidx_q + CW'(1);
    end else begin
      slot_q <= slot_q + SW'(1);
    end
  end

  // Merge the current sample into the running frame so the frame-end decision sees it too.
  always_comb begin
    mrg_hit   = acc_hit_q;
    mrg_multi = acc_multi_q;
    mrg_col   = acc_col_q;
    mrg_row   = acc_row_q;
    if (sample && (row_low != '0)) begin
      if (((row_low & (row_low - NROW'(1))) != '0) || (acc_hit_q && (acc_col_q != samp_col)))
        mrg_multi = 1'b1;
      if (!acc_hit_q) begin
        mrg_col = samp_col;
        mrg_row = lowest_row(row_low);
      end
      mrg_hit = 1'b1;
    end
  end

  always_comb begin
    if (!mrg_hit)      res_kind = NONE;
    else if (mrg_multi) res_kind = MULTI;
    else               res_kind = SINGLE;
  end

  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      acc_hit_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_col_q   <= '0;
      acc_row_q   <= '0;
    end else begin
      acc_hit_q   <= mrg_hit;
      acc_multi_q <= mrg_multi;
      acc_col_q   <= mrg_col;
      acc_row_q   <= mrg_row;
    end
  end

  assign res_key   = (res_kind == SINGLE);
  assign same_cand = (mrg_col == cand_col_q) && (mrg_row == cand_row_q);
  assign same_held = (mrg_col == col_q) && (mrg_row == row_q);
  assign cnt_inc   = cnt_q + DW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    col_d      = col_q;
    row_d      = row_q;
    valid_d    = valid_q;
    pulse_d    = 1'b0;
    if (frame_end) begin
      case (state_q)
        RELEASED: begin
          if (res_key) begin
            if (DEB_SCANS <= 1) begin
              state_d = PRESSED;
              col_d   = mrg_col;
              row_d   = mrg_row;
              valid_d = 1'b1;
              pulse_d = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d    = PRESS_PEND;
              cand_col_d = mrg_col;
              cand_row_d = mrg_row;
              cnt_d      = DW'(1);
            end
          end
        end
        PRESS_PEND: begin
          if (!res_key) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (same_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) begin
              state_d = PRESSED;
              col_d   = mrg_col;
              row_d   = mrg_row;
              valid_d = 1'b1;
              pulse_d = 1'b1;
              cnt_d   = '0;
            end
          end else begin
            cand_col_d = mrg_col;
            cand_row_d = mrg_row;
            cnt_d      = DW'(1);
          end
        end
        PRESSED: begin
          if (!(res_key && same_held)) begin
            if (DEB_SCANS <= 1) begin
              state_d = RELEASED;
              col_d   = '0;
              row_d   = '0;
              valid_d = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE_PEND;
              cnt_d   = DW'(1);
            end
          end
        end
        RELEASE_PEND: begin
          if (res_key && same_held) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) begin
              state_d = RELEASED;
              col_d   = '0;
              row_d   = '0;
              valid_d = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      cand_col_q <= '0;
      cand_row_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_col_q <= cand_col_d;
      cand_row_q <= cand_row_d;
      col_q      <= col_d;
      row_q      <= row_d;
      valid_q    <= valid_d;
      pulse_q    <= pulse_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign key_valid = valid_q;
  assign key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench: a frame-level key-set model predicts output events; a negedge monitor checks them.
module tb_keypad_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 2;
  localparam int FRAME     = 5 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] col_n;
  logic [3:0] row_n;
  logic [2:0] col, row;
  logic       key_valid, key_pulse;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int c;
    int r;
    int v;
    int p;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ph = 0;
  logic [19:0] keymask = '0;
  int          held_c = 0, held_r = 0, cand_c = 0, cand_r = 0, streak = 0;
  logic [6:0]  last_out = '0;

  // Physical matrix: a pressed key shorts its column drive onto its row line.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < 5; c++)
      for (int j = 0; j < 4; j++)
        if (!col_n[c] && keymask[c*4+j]) row_n[j] = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ph  <= rst ? 0 : (ph + 1) % FRAME;
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [4:0] exp_coln;
    ev_t        e;
    exp_coln = ~(5'(1) << (ph / SCAN_DIV));
    check("col_n", int'(col_n), int'(exp_coln));
    check("valid_vs_col", int'(key_valid), int'(col != 3'd0));
    if (key_pulse || ({col, row, key_valid} != last_out)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: col=%0d row=%0d valid=%0d pulse=%0d at cycle %0d, expected no event",
                 col, row, key_valid, key_pulse, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_col", int'(col), e.c);
        check("event_row", int'(row), e.r);
        check("event_valid", int'(key_valid), e.v);
        check("event_pulse", int'(key_pulse), e.p);
      end
      last_out = {col, row, key_valid};
    end
  end

  function automatic logic [19:0] kb(input int c, input int r);
    logic [19:0] m;
    m = '0;
    m[(c-1)*4 + (r-1)] = 1'b1;
    return m;
  endfunction

  task automatic push_ev(input int at, input int c, input int r, input int v, input int p);
    ev_t e;
    e.cyc = at; e.c = c; e.r = r; e.v = v; e.p = p;
    exp_q.push_back(e);
  endtask

  // Frame-level debounce model: one decision per frame from the set of keys held that frame.
  task automatic model_frame(input logic [19:0] m, input int end_cyc);
    int c, r;
    c = 0; r = 0;
    if ($countones(m) == 1) begin
      for (int i = 0; i < 20; i++)
        if (m[i]) begin c = i / 4 + 1; r = i % 4 + 1; end
    end
    if (held_c == 0) begin
      if (c != 0) begin
        if (c == cand_c && r == cand_r) streak++;
        else begin cand_c = c; cand_r = r; streak = 1; end
        if (streak == DEB_SCANS) begin
          held_c = c; held_r = r; streak = 0; cand_c = 0; cand_r = 0;
          push_ev(end_cyc, c, r, 1, 1);
        end
      end else begin
        streak = 0; cand_c = 0; cand_r = 0;
      end
    end else begin
      if (c == held_c && r == held_r) streak = 0;
      else streak++;
      if (streak == DEB_SCANS) begin
        held_c = 0; held_r = 0; streak = 0;
        push_ev(end_cyc, 0, 0, 0, 0);
      end
    end
  endtask

  // Called at the negedge inside slot 0 of a frame; returns at the next frame's slot-0 negedge.
  task automatic run_frame(input logic [19:0] m);
    keymask = m;
    model_frame(m, cyc + FRAME);
    repeat (FRAME) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic partial_frame(input logic [19:0] m, input int n);
    keymask = m;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keymask = '0;
    if (held_c != 0) push_ev(cyc + 1, 0, 0, 0, 0);
    held_c = 0; held_r = 0; cand_c = 0; cand_r = 0; streak = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [19:0] m;
    int sel, s2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_frame('0);
    run_frame('0);

    // accept (3,2), survive a one-frame dropout, then release
    run_frame(kb(3, 2));
    run_frame(kb(3, 2));
    run_frame(kb(3, 2));
    run_frame('0);
    run_frame(kb(3, 2));
    run_frame('0);
    run_frame('0);

    // bounce on (1,4)
    run_frame(kb(1, 4));
    run_frame('0);
    run_frame(kb(1, 4));
    run_frame(kb(1, 4));
    run_frame('0);
    run_frame('0);

    // roll-over (2,1) then (5,3)
    run_frame(kb(2, 1));
    run_frame(kb(2, 1));
    run_frame(kb(2, 1) | kb(5, 3));
    run_frame(kb(2, 1) | kb(5, 3));
    run_frame(kb(5, 3));
    run_frame(kb(5, 3));
    run_frame('0);
    run_frame('0);

    // same-column double press is MULTI; different candidate restarts the count
    run_frame(kb(4, 1) | kb(4, 3));
    run_frame(kb(4, 1) | kb(4, 3));
    run_frame(kb(1, 1));
    run_frame(kb(5, 4));
    run_frame(kb(5, 4));
    run_frame('0);
    run_frame('0);

    // reset during PRESS_PEND, then during PRESSED
    run_frame(kb(4, 4));
    partial_frame(kb(4, 4), 7);
    do_reset();
    run_frame('0);
    run_frame(kb(4, 4));
    run_frame(kb(4, 4));
    partial_frame(kb(4, 4), 9);
    do_reset();
    run_frame('0);
    run_frame('0);

    m = '0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 99);
      if (sel >= 55) begin
        s2 = $urandom_range(0, 99);
        m = '0;
        if (s2 >= 35) m = kb($urandom_range(1, 5), $urandom_range(1, 4));
        if (s2 >= 85) m = m | kb($urandom_range(1, 5), $urandom_range(1, 4));
      end
      run_frame(m);
    end
    run_frame('0);
    run_frame('0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("events_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
